// File: rtl/adpcm_nibble_packer.sv
// adpcm_nibble_packer
// Collects 4-bit ADPCM codes MSB-first into 16-bit words and queues the
// words in a small FIFO. A flush emits a partially filled word with its low
// nibbles zero-filled. The FIFO head is presented on registered outputs.
module adpcm_nibble_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        block_enable,
  input  logic        inValid,
  input  logic [3:0]  encPcm,
  input  logic        flush,
  output logic [15:0] outData,
  output logic        outValid,
  input  logic        outReady,
  output logic [4:0]  fifoCount,
  output logic        overflow
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  // Packing state
  logic [1:0]    r_idx;
  logic [15:0]   r_partial;

  // FIFO state
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_overflow;
  logic          r_out_valid;
  logic [15:0]   r_out_data;

  // Next-state and control wires
  logic          w_accept;
  logic [15:0]   w_merged;
  logic [15:0]   w_word;
  logic          w_word_done;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [4:0]    w_count_nxt;
  logic [15:0]   w_head_nxt;

  // Nibble placement into the partial word at the current index
  always_comb begin
    w_merged = r_partial;
    case (r_idx)
      2'd0:    w_merged = {encPcm, r_partial[11:0]};
      2'd1:    w_merged = {r_partial[15:12], encPcm, r_partial[7:0]};
      2'd2:    w_merged = {r_partial[15:8], encPcm, r_partial[3:0]};
      2'd3:    w_merged = {r_partial[15:4], encPcm};
      default: w_merged = r_partial;
    endcase
  end

  // Word completion, FIFO push/pop decisions and next head word
  always_comb begin
    w_accept    = inValid & block_enable;
    w_word      = w_accept ? w_merged : r_partial;
    // A flush on an empty index with no nibble arriving is a no-op; a nibble
    // that completes the word together with a flush still yields one word.
    w_word_done = (w_accept && (r_idx == 2'd3)) ||
                  (flush && ((r_idx != 2'd0) || w_accept));
    w_pop       = r_out_valid & outReady;
    w_full      = (r_count == DEPTH_C);
    w_push      = w_word_done & (~w_full | w_pop);
    w_drop      = w_word_done & w_full & ~w_pop;

    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 5'd1;
      2'b01:   w_count_nxt = r_count - 5'd1;
      default: w_count_nxt = r_count;
    endcase

    // The new head may be the word being written on this very edge
    if (w_count_nxt == 5'd0) begin
      w_head_nxt = 16'h0000;
    end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = w_word;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // FIFO storage write; stale entries are unreachable after reset
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Packing index, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= 2'd0;
      r_partial   <= 16'h0000;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 5'd0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
    end else begin
      if (w_word_done) begin
        r_idx     <= 2'd0;
        r_partial <= 16'h0000;
      end else if (w_accept) begin
        r_idx     <= r_idx + 2'd1;
        r_partial <= w_merged;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != 5'd0);
      r_out_data  <= w_head_nxt;
    end
  end

  assign outData   = r_out_data;
  assign outValid  = r_out_valid;
  assign fifoCount = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_adpcm_nibble_packer.sv
// Testbench for adpcm_nibble_packer: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_adpcm_nibble_packer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        block_enable;
  logic        inValid;
  logic [3:0]  encPcm;
  logic        flush;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;
  logic [4:0]  fifoCount;
  logic        overflow;

  adpcm_nibble_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .block_enable (block_enable),
    .inValid      (inValid),
    .encPcm       (encPcm),
    .flush        (flush),
    .outData      (outData),
    .outValid     (outValid),
    .outReady     (outReady),
    .fifoCount    (fifoCount),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: nibbles of the word in progress, queued words
  logic [3:0]  m_nibs[$];
  logic [15:0] m_fifo[$];
  bit          m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] compose();
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < m_nibs.size(); i++) begin
      w = w | (16'(m_nibs[i]) << (12 - 4 * i));
    end
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit          pop;
    logic [15:0] w;
    if (reset) begin
      m_nibs.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (m_fifo.size() > 0) && outReady;
      if (inValid && block_enable) m_nibs.push_back(encPcm);
      if (pop) void'(m_fifo.pop_front());
      if (m_nibs.size() == 4 || (flush && m_nibs.size() > 0)) begin
        w = compose();
        m_nibs.delete();
        if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("outValid",  32'(outValid),  32'(m_fifo.size() != 0));
    check_eq("outData",   32'(outData),   (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
    check_eq("fifoCount", 32'(fifoCount), 32'(m_fifo.size()));
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic send(input logic [3:0] n, input logic fl);
    block_enable = 1'b1;
    inValid      = 1'b1;
    encPcm       = n;
    flush        = fl;
    tick();
    inValid      = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] exp_w [9];
  int          bias;

  initial begin
    reset        = 1'b0;
    block_enable = 1'b1;
    inValid      = 1'b0;
    encPcm       = 4'h0;
    flush        = 1'b0;
    outReady     = 1'b0;
    m_ovf        = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_valid", 32'(outValid),  32'h0);
    check_eq("rst_data",  32'(outData),   32'h0);
    check_eq("rst_count", 32'(fifoCount), 32'h0);
    check_eq("rst_ovf",   32'(overflow),  32'h0);

    // Four codes form 16'h1234, visible for exactly one cycle with outReady=1
    outReady = 1'b1;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    check_eq("w1234_early", 32'(outValid), 32'h0);
    send(4'h4, 1'b0);
    check_eq("w1234_data",  32'(outData),  32'h1234);
    check_eq("w1234_valid", 32'(outValid), 32'h1);
    tick();
    check_eq("w1234_once",  32'(outValid), 32'h0);

    // Flush of a two-nibble word, then a flush on an empty index
    outReady = 1'b0;
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    check_eq("flush_data",  32'(outData),   32'hAB00);
    check_eq("flush_count", 32'(fifoCount), 32'h1);
    flush = 1'b1; tick(); flush = 1'b0;
    check_eq("flush_noop",  32'(fifoCount), 32'h1);
    outReady = 1'b1; tick(); outReady = 1'b0;

    // Nibble and flush on the same edge
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b1);
    check_eq("nibflush_data",  32'(outData),   32'h5670);
    check_eq("nibflush_count", 32'(fifoCount), 32'h1);
    tick();
    check_eq("nibflush_one",   32'(fifoCount), 32'h1);

    // Overflow: nine words into an eight-deep FIFO, then drain in order
    do_reset();
    outReady = 1'b0;
    for (int w = 0; w < 9; w++) begin
      exp_w[w] = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        send(exp_w[w][15 - 4 * k -: 4], 1'b0);
      end
    end
    check_eq("ovf_count", 32'(fifoCount), 32'd8);
    check_eq("ovf_flag",  32'(overflow),  32'h1);
    outReady = 1'b1;
    for (int w = 0; w < 8; w++) begin
      check_eq("ovf_drain", 32'(outData), 32'(exp_w[w]));
      tick();
    end
    check_eq("ovf_empty", 32'(outValid), 32'h0);
    check_eq("ovf_sticky", 32'(overflow), 32'h1);

    // Full FIFO with simultaneous push and pop does not overflow
    do_reset();
    outReady = 1'b0;
    for (int i = 0; i < 35; i++) send(4'($urandom), 1'b0);
    check_eq("full_count", 32'(fifoCount), 32'd8);
    outReady = 1'b1;
    send(4'hC, 1'b0);
    outReady = 1'b0;
    check_eq("pushpop_ovf",   32'(overflow),  32'h0);
    check_eq("pushpop_count", 32'(fifoCount), 32'd8);

    // Reset mid-word with three words queued, then a fresh word
    do_reset();
    outReady = 1'b0;
    for (int i = 0; i < 14; i++) send(4'($urandom), 1'b0);
    check_eq("pre_rst_count", 32'(fifoCount), 32'd3);
    reset = 1'b1; inValid = 1'b1; flush = 1'b1; outReady = 1'b1; encPcm = 4'hF;
    tick();
    reset = 1'b0; inValid = 1'b0; flush = 1'b0; outReady = 1'b0;
    check_eq("midrst_count", 32'(fifoCount), 32'h0);
    check_eq("midrst_valid", 32'(outValid),  32'h0);
    check_eq("midrst_ovf",   32'(overflow),  32'h0);
    send(4'h9, 1'b0);
    send(4'h8, 1'b0);
    send(4'h7, 1'b0);
    send(4'h6, 1'b0);
    check_eq("fresh_data",  32'(outData),   32'h9876);
    check_eq("fresh_count", 32'(fifoCount), 32'h1);

    // Block disabled keeps the partial word and still drains
    send(4'h1, 1'b0);
    block_enable = 1'b0; inValid = 1'b1; encPcm = 4'hE; outReady = 1'b1;
    tick(); tick();
    inValid = 1'b0; outReady = 1'b0;
    check_eq("dis_drain", 32'(fifoCount), 32'h0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    check_eq("dis_keep", 32'(outData), 32'h1234);

    // Randomized traffic with varying consumer pressure
    bias = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) bias = $urandom_range(5, 95);
      reset        = ($urandom_range(0, 399) == 0);
      block_enable = ($urandom_range(0, 9) != 0);
      inValid      = ($urandom_range(0, 3) != 0);
      encPcm       = 4'($urandom);
      flush        = ($urandom_range(0, 9) == 0);
      outReady     = ($urandom_range(0, 99) < bias);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adpcm_nibble_packer.md
ADPCM_NIBBLE_PACKER -- requirements
Module: adpcm_nibble_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, words of packed-output buffering (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port block_enable, input, 1, which gates nibble acceptance only.
REQ-005 SHALL have port inValid, input, 1, which qualifies encPcm (driven by the encoder outValid).
REQ-006 SHALL have port encPcm, input, 4, the signed ADPCM code, packed as raw bits.
REQ-007 SHALL have port flush, input, 1, a single-cycle request to emit a partial word.
REQ-008 SHALL have port outData, output, 16, the FIFO head word.
REQ-009 SHALL have port outValid, output, 1, which is high when the FIFO is non-empty.
REQ-010 SHALL have port outReady, input, 1, the consumer acceptance signal.
REQ-011 SHALL have port fifoCount, output, 5, the number of words held (0..FIFO_DEPTH).
REQ-012 SHALL have port overflow, output, 1, a sticky flag for a dropped word.

Function
REQ-013 SHALL accept a nibble on any edge where inValid=1 and block_enable=1; inValid is ignored while block_enable=0.
REQ-014 SHALL pack nibbles MSB-first: 1st nibble to [15:12], 2nd to [11:8], 3rd to [7:4], 4th to [3:0].
REQ-015 SHALL keep a nibble index 0..3; acceptance of the 4th nibble wraps the index to 0 and pushes the word into the FIFO on the same edge.
REQ-016 SHALL raise outValid and present the word on outData one cycle after the edge that accepted the 4th nibble, when the FIFO was empty.
REQ-017 SHALL handle flush with index>0 by zero-filling the unfilled low nibbles, pushing the word, and setting index to 0.
REQ-018 SHALL treat flush with index=0 as a no-op.
REQ-019 SHALL, when flush and an accepted nibble occur on the same edge, place the nibble first and then apply the flush to the resulting word; exactly one word is pushed.
REQ-020 SHALL pop on an edge where outValid=1 and outReady=1, and present the next entry on outData on the following cycle.
REQ-021 SHALL hold outData and outValid stable while outValid=1 and outReady=0.
REQ-022 SHALL drop a pushed word when the FIFO is full with no pop on the same edge, and set overflow to 1.
REQ-023 SHALL, on a push and pop on the same edge with the FIFO full, complete both; fifoCount stays FIFO_DEPTH and overflow is not set.
REQ-024 SHALL, on a push and pop on the same edge at any level, leave fifoCount unchanged.
REQ-025 SHALL drive outData=0 while outValid=0.
REQ-026 SHALL keep draining the FIFO via outReady while block_enable=0.
REQ-027 SHALL keep the partial word and index intact while block_enable=0; deasserting block_enable does not flush.
REQ-028 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; fifoCount is the sole full/empty indicator.
REQ-029 SHALL clear overflow only by reset.

Reset
REQ-030 SHALL, on a reset edge, clear the index, partial word, FIFO pointers, fifoCount, overflow, outValid and outData to 0.
REQ-031 SHALL, on a reset edge, discard any partial word or stored entries without emitting them.
REQ-032 SHALL give reset priority over inValid, flush and outReady on the same edge.

Verification
REQ-033 SHALL be verified with: outReady=1, codes 1,2,3,4 on consecutive cycles -> outData=16'h1234 and outValid=1 one cycle after the 4th code, for exactly one cycle.
REQ-034 SHALL be verified with: codes 4'hA, 4'hB, then flush alone -> single word 16'hAB00; a following flush alone -> no word.
REQ-035 SHALL be verified with: 3rd code 4'h7 and flush on the same edge after 4'h5, 4'h6 -> single word 16'h5670.
REQ-036 SHALL be verified with: outReady=0, 36 codes (9 words) at FIFO_DEPTH=8 -> fifoCount=8, overflow=1, first 8 words intact and in order once drained.
REQ-037 SHALL be verified with: FIFO full, outReady=1 on the edge that completes a 9th word -> overflow stays 0, fifoCount stays 8.
REQ-038 SHALL be verified with: reset asserted mid-word (index=2) with 3 words queued -> next cycle fifoCount=0, outValid=0, overflow=0; the next 4 codes form a fresh word.
